// File: rtl/pwm_width_scheduler.sv
// Buffers host pulse-width words and applies each one to the PWM top only at a
// 1 MHz period boundary: enable off, load pulse, wait for decoder done, re-enable.
module pwm_width_scheduler #(
  parameter int W_WIDTH = 13,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       wr_valid,
  input  logic [W_WIDTH-1:0]         wr_data,
  output logic                       wr_ready,
  input  logic                       tick_1MHz,
  input  logic                       dec_done,
  output logic [W_WIDTH-1:0]         W_out,
  output logic                       load_out,
  output logic                       en_out,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_LOAD, S_DECODE, S_RUN, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [W_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [W_WIDTH-1:0] w_out_q, w_out_d;
  logic               load_q, load_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic push, capture, count_nz;

  // Full flag is taken from the registered count only, so a pop never frees
  // a slot for a push in the same cycle.
  assign wr_ready = (count_q < DEPTH_C);
  assign count_nz = (count_q != '0);
  assign push     = wr_valid && wr_ready;
  assign capture  = ((state_q == S_ARM) || (state_q == S_RUN)) && run && tick_1MHz && count_nz;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    w_out_d  = w_out_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (capture) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      w_out_d  = mem_q[rd_ptr_q];
    end
    if (push && !capture) begin
      count_d = count_q + 1'b1;
    end else if (!push && capture) begin
      count_d = count_q - 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (run && count_nz) state_d = S_ARM;
      end
      S_ARM: begin
        if (!run)         state_d = S_IDLE;
        else if (capture) state_d = S_LOAD;
      end
      S_LOAD: begin
        timer_d = '0;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        timer_d = timer_q + 1'b1;
        // timer_q == 0 marks the first DECODE cycle, where done is stale.
        if (!run)                               state_d = S_IDLE;
        else if (dec_done && timer_q != '0)     state_d = S_RUN;
        else if (timer_q == TIMER_END)          state_d = S_ERR;
      end
      S_RUN: begin
        if (!run)         state_d = S_IDLE;
        else if (capture) state_d = S_LOAD;
      end
      S_ERR: begin
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies decoded from the next state.
    load_d = (state_d == S_LOAD);
    en_d   = (state_d == S_RUN);
    busy_d = (state_d == S_LOAD) || (state_d == S_DECODE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      w_out_q  <= '0;
      load_q   <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      w_out_q  <= w_out_d;
      load_q   <= load_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign W_out       = w_out_q;
  assign load_out    = load_q;
  assign en_out      = en_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;
  assign fifo_count  = count_q;

endmodule
